// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and high time of an external PWM input in
// clk cycles and exposes the results on a simple register bus.
//
// Bus handshake: a write takes effect on the clk edge where bus_we is high
// (one cycle per write, no wait states). bus_rdata is combinational from
// bus_addr and always valid; there is no read strobe and no backpressure.
module pwm_capture #(
    parameter int          CNT_W   = 32,
    parameter logic [31:0] TMO_RST = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        pwm_in,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_INIT = TMO_RST[CNT_W-1:0];

    state_e           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] tmo_reg_q, tmo_reg_d;
    logic             valid_q, valid_d;
    logic             tmo_flag_q, tmo_flag_d;
    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;

    logic             rise, fall;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] wdata_cnt;
    logic [2:0]       reg_sel;
    logic             wr_ctrl, wr_status, wr_tmo;
    logic             measuring, do_capture, do_hi_latch, do_timeout;
    logic             unused_bus_bits;

    // Address bits outside [4:2] and data bits beyond the register widths are ignored.
    assign unused_bus_bits = ^{bus_addr[31:5], bus_addr[1:0], bus_wdata};

    // Edge detection on the synchronized input, saturating count+1 and bus decode.
    always_comb begin
        rise      = s2_q & ~prev_q;
        fall      = ~s2_q & prev_q;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        wdata_cnt = bus_wdata[CNT_W-1:0];
        reg_sel   = bus_addr[4:2];
        wr_ctrl   = bus_we && (reg_sel == 3'd0);
        wr_status = bus_we && (reg_sel == 3'd3);
        wr_tmo    = bus_we && (reg_sel == 3'd4);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: first rise arms, second rise starts running; timeout or disable drops to IDLE.
    always_comb begin
        state_d = state_q;
        if (!en_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (rise) state_d = ARMED;
                ARMED:   if (rise) state_d = RUN;
                         else if (do_timeout) state_d = IDLE;
                RUN:     if (do_timeout) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: capture strobes, only while enabled and measuring.
    always_comb begin
        measuring   = en_q && (state_q != IDLE);
        do_capture  = measuring && rise;
        do_hi_latch = measuring && fall;
        do_timeout  = measuring && !rise && (cnt_inc >= tmo_reg_q);
    end

    // Datapath next values: counter, latches, captures, W1C flags (set wins) and control registers.
    always_comb begin
        s1_d       = pwm_in;
        s2_d       = s1_q;
        prev_d     = s2_q;
        cnt_d      = cnt_q;
        if (en_q) cnt_d = rise ? '0 : cnt_inc;
        hi_lat_d   = do_hi_latch ? cnt_inc : hi_lat_q;
        period_d   = do_capture ? cnt_inc : period_q;
        high_d     = do_capture ? hi_lat_q : high_q;
        valid_d    = do_capture | (valid_q & ~(wr_status & bus_wdata[0]));
        tmo_flag_d = do_timeout | (tmo_flag_q & ~(wr_status & bus_wdata[1]));
        en_d       = wr_ctrl ? bus_wdata[0] : en_q;
        irq_en_d   = wr_ctrl ? bus_wdata[1] : irq_en_q;
        tmo_reg_d  = tmo_reg_q;
        if (wr_tmo) tmo_reg_d = (wdata_cnt == '0) ? CNT_ONE : wdata_cnt;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            prev_q     <= 1'b0;
            cnt_q      <= '0;
            hi_lat_q   <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            tmo_flag_q <= 1'b0;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            tmo_reg_q  <= TMO_INIT;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            hi_lat_q   <= hi_lat_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            tmo_flag_q <= tmo_flag_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            tmo_reg_q  <= tmo_reg_d;
        end
    end

    // Read mux; unmapped addresses and unused upper bits read 0.
    always_comb begin
        bus_rdata = '0;
        case (reg_sel)
            3'd0:    bus_rdata[1:0] = {irq_en_q, en_q};
            3'd1:    bus_rdata[CNT_W-1:0] = period_q;
            3'd2:    bus_rdata[CNT_W-1:0] = high_q;
            3'd3:    bus_rdata[2:0] = {s2_q, tmo_flag_q, valid_q};
            3'd4:    bus_rdata[CNT_W-1:0] = tmo_reg_q;
            default: ;
        endcase
    end

    assign irq = valid_q & irq_en_q;

endmodule
